mem_wb_stage: RTL and testbench

//  Memory stage plus MEM/WB pipeline register; sits directly downstream of EX/MEM.

---
 rtl/mem_wb_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory stage plus MEM/WB pipeline register. Issues loads and
//                stores on a req/ack data bus, stalls upstream until the ack
//                arrives or a bounded wait expires, then selects the writeback
//                value and registers rd/reg_wr/result for the WB stage.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk, i_rst        clock (rising edge) / synchronous active-high reset
//    i_clk_en            global enable; 0 freezes all state
//    i_rd_m .. i_mem_write_m
//                        EX/MEM pipeline register contents
//    o_bus_req/we/addr/wdata, i_bus_ack, i_bus_rdata
//                        req/ack data bus (addr/wdata latched at issue)
//    o_stall_m           combinational hold request to EX/MEM and earlier
//    o_misaligned_m      combinational misaligned-access flag
//    o_bus_err           one-cycle pulse when a transaction times out
//    o_rd_w, o_reg_wr_w, o_result_w
//                        MEM/WB pipeline register
// ============================================================================
module mem_wb_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic [4:0]  i_rd_m,
    input  logic [31:0] i_alu_out_m,
    input  logic [31:0] i_haz_b_m,
    input  logic [31:0] i_pc_p4_m,
    input  logic        i_reg_wr_m,
    input  logic [1:0]  i_result_src_m,
    input  logic        i_mem_write_m,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata,
    output logic        o_stall_m,
    output logic        o_misaligned_m,
    output logic        o_bus_err,
    output logic [4:0]  o_rd_w,
    output logic        o_reg_wr_w,
    output logic [31:0] o_result_w
);

    // Last WAIT-cycle count value before the transaction is abandoned.
    localparam logic [7:0] c_to_last = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [4:0]  r_rd;
    logic        r_reg_wr;
    logic [31:0] r_result;

    logic        w_access;
    logic        w_aligned;
    logic        w_in_wait;
    logic        w_issue;
    logic        w_timeout;
    logic [31:0] w_mux;

    assign w_access  = i_mem_write_m | (i_result_src_m == 2'b01);
    assign w_aligned = (i_alu_out_m[1:0] == 2'b00);
    assign w_in_wait = (r_state == S_WAIT);
    assign w_issue   = (r_state == S_IDLE) & w_access & w_aligned;
    // An ack arriving on the final WAIT cycle takes precedence over timeout.
    assign w_timeout = w_in_wait & ~i_bus_ack & (r_cnt == c_to_last);

    assign o_stall_m      = w_issue | (w_in_wait & ~i_bus_ack & ~w_timeout);
    assign o_misaligned_m = w_access & ~w_aligned;

    // Writeback source select. Load data is only meaningful on the ack cycle;
    // in IDLE a load never reaches the writeback path.
    always_comb begin
        w_mux = 32'd0;
        case (i_result_src_m)
            2'b00:   w_mux = i_alu_out_m;
            2'b01:   w_mux = i_bus_rdata;
            2'b10:   w_mux = i_pc_p4_m;
            default: w_mux = 32'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_err    <= 1'b0;
            r_rd     <= 5'd0;
            r_reg_wr <= 1'b0;
            r_result <= 32'd0;
        end else if (i_clk_en) begin
            r_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        // Memory ops (issued or rejected) leave a bubble in WB.
                        r_rd     <= 5'd0;
                        r_reg_wr <= 1'b0;
                        r_result <= 32'd0;
                        if (w_aligned) begin
                            r_state <= S_WAIT;
                            r_req   <= 1'b1;
                            r_we    <= i_mem_write_m;
                            r_addr  <= {i_alu_out_m[31:2], 2'b00};
                            r_wdata <= i_haz_b_m;
                            r_cnt   <= 8'd0;
                        end
                    end else begin
                        r_rd     <= i_rd_m;
                        r_reg_wr <= i_reg_wr_m;
                        r_result <= w_mux;
                    end
                end
                S_WAIT: begin
                    if (i_bus_ack) begin
                        r_state  <= S_IDLE;
                        r_req    <= 1'b0;
                        r_rd     <= i_rd_m;
                        r_reg_wr <= i_reg_wr_m;
                        r_result <= w_mux;
                    end else if (w_timeout) begin
                        r_state  <= S_IDLE;
                        r_req    <= 1'b0;
                        r_err    <= 1'b1;
                        r_rd     <= 5'd0;
                        r_reg_wr <= 1'b0;
                        r_result <= 32'd0;
                    end else begin
                        r_rd     <= 5'd0;
                        r_reg_wr <= 1'b0;
                        r_result <= 32'd0;
                        if (r_cnt != 8'hFF) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bus_req   = r_req;
    assign o_bus_we    = r_we;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_err   = r_err;
    assign o_rd_w      = r_rd;
    assign o_reg_wr_w  = r_reg_wr;
    assign o_result_w  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage (TIMEOUT_CYCLES = 4).
//                Directed scenarios with literal expectations, followed by
//                randomized traffic compared every cycle against a
//                transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [4:0]  rd_m = '0;
    logic [31:0] alu_m = '0;
    logic [31:0] hazb_m = '0;
    logic [31:0] pc_m = '0;
    logic        regwr_m = 1'b0;
    logic [1:0]  src_m = '0;
    logic        memw_m = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;

    logic        bus_req, bus_we, stall, mis, bus_err, reg_wr_w;
    logic [31:0] bus_addr, bus_wdata, result_w;
    logic [4:0]  rd_w;

    int n_pass = 0;
    int n_tot  = 0;
    bit done   = 1'b0;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_clk_en       (en),
        .i_rd_m         (rd_m),
        .i_alu_out_m    (alu_m),
        .i_haz_b_m      (hazb_m),
        .i_pc_p4_m      (pc_m),
        .i_reg_wr_m     (regwr_m),
        .i_result_src_m (src_m),
        .i_mem_write_m  (memw_m),
        .o_bus_req      (bus_req),
        .o_bus_we       (bus_we),
        .o_bus_addr     (bus_addr),
        .o_bus_wdata    (bus_wdata),
        .i_bus_ack      (ack),
        .i_bus_rdata    (rdata),
        .o_stall_m      (stall),
        .o_misaligned_m (mis),
        .o_bus_err      (bus_err),
        .o_rd_w         (rd_w),
        .o_reg_wr_w     (reg_wr_w),
        .o_result_w     (result_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // ---------------- reference model (transaction level) ----------------
    // One outstanding bus transaction at most; 'waited' counts the WAIT
    // cycles it has already spent without an ack.
    bit        m_busy;
    int        m_waited;
    bit        m_req, m_we, m_err, m_regwr;
    bit [31:0] m_addr, m_wdata, m_res;
    bit [4:0]  m_rd;
    bit        e_stall;   // expected stall of the current cycle

    function automatic bit [31:0] wb_value(input bit [1:0] s, input bit [31:0] a,
                                           input bit [31:0] p, input bit [31:0] d);
        if (s == 2'd0) return a;
        if (s == 2'd1) return d;
        if (s == 2'd2) return p;
        return 32'd0;
    endfunction

    always @(negedge clk) begin
        if (!done) begin
            bit acc, al;
            acc = memw_m | (src_m == 2'b01);
            al  = (alu_m[1:0] == 2'b00);
            e_stall = (!m_busy && acc && al) || (m_busy && !ack && (m_waited < TO - 1));

            chk("stall",    {31'd0, stall},    {31'd0, e_stall});
            chk("misalign", {31'd0, mis},      {31'd0, acc & ~al});
            chk("req",      {31'd0, bus_req},  {31'd0, m_req});
            chk("we",       {31'd0, bus_we},   {31'd0, m_we});
            chk("addr",     bus_addr,          m_addr);
            chk("wdata",    bus_wdata,         m_wdata);
            chk("bus_err",  {31'd0, bus_err},  {31'd0, m_err});
            chk("rd_w",     {27'd0, rd_w},     {27'd0, m_rd});
            chk("reg_wr_w", {31'd0, reg_wr_w}, {31'd0, m_regwr});
            chk("result_w", result_w,          m_res);

            // advance the model by the coming rising edge
            if (rst) begin
                m_busy = 0; m_waited = 0; m_req = 0; m_we = 0; m_err = 0;
                m_addr = 0; m_wdata = 0; m_rd = 0; m_regwr = 0; m_res = 0;
            end else if (en) begin
                m_err = 0;
                m_rd = 0; m_regwr = 0; m_res = 0;
                if (m_busy) begin
                    if (ack) begin
                        m_busy = 0; m_req = 0;
                        m_rd = rd_m; m_regwr = regwr_m;
                        m_res = wb_value(src_m, alu_m, pc_m, rdata);
                    end else if (m_waited == TO - 1) begin
                        m_busy = 0; m_req = 0; m_err = 1;
                    end else begin
                        m_waited++;
                    end
                end else if (acc && al) begin
                    m_busy = 1; m_waited = 0; m_req = 1; m_we = memw_m;
                    m_addr = {alu_m[31:2], 2'b00}; m_wdata = hazb_m;
                end else if (!acc) begin
                    m_rd = rd_m; m_regwr = regwr_m;
                    m_res = wb_value(src_m, alu_m, pc_m, rdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_op(input bit [4:0] r, input bit [31:0] a, input bit [31:0] b,
                          input bit w, input bit [1:0] s, input bit mw);
        rd_m = r; alu_m = a; hazb_m = b; regwr_m = w; src_m = s; memw_m = mw;
        pc_m = $urandom;
    endtask

    task automatic nop();
        set_op(5'd0, 32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
    endtask

    task automatic rand_op();
        int k;
        bit [31:0] a;
        k = $urandom_range(0, 4);
        a = $urandom;
        case (k)
            0: set_op(5'($urandom), a, $urandom, 1'($urandom), 2'b00, 1'b0);
            1: set_op(5'($urandom), {a[31:2], 2'b00}, $urandom, 1'($urandom), 2'b01, 1'b0);
            2: set_op(5'($urandom), {a[31:2], 2'b00}, $urandom, 1'($urandom), 2'b00, 1'b1);
            3: set_op(5'($urandom), {a[31:2], 2'($urandom_range(1, 3))}, $urandom,
                      1'($urandom), 2'($urandom_range(0, 1)), 1'($urandom));
            default: set_op(5'($urandom), a, $urandom, 1'($urandom), 2'($urandom_range(2, 3)), 1'b0);
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int st, rq, er;
        bit stall_now, adv;

        // reset state
        @(negedge clk);
        chk("rst req", {31'd0, bus_req}, 32'd0);
        chk("rst result", result_w, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;

        // ALU op: 1-cycle writeback
        set_op(5'd5, 32'h1234, 32'd0, 1'b1, 2'b00, 1'b0);
        @(negedge clk); chk("alu stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("alu rd_w", {27'd0, rd_w}, 32'd5);
        chk("alu reg_wr_w", {31'd0, reg_wr_w}, 32'd1);
        chk("alu result_w", result_w, 32'h1234);

        // load 0x100, ack on the 4th WAIT cycle (last before timeout)
        @(posedge clk); #2;
        set_op(5'd7, 32'h100, 32'd0, 1'b1, 2'b01, 1'b0);
        st = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            st += int'(stall);
            if (i == 1) begin
                chk("ld req", {31'd0, bus_req}, 32'd1);
                chk("ld we", {31'd0, bus_we}, 32'd0);
                chk("ld addr", bus_addr, 32'h100);
            end
            @(posedge clk); #2;
        end
        ack = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld ack stall", {31'd0, stall}, 32'd0);
        chk("ld stall cycles", st, 32'd4);
        @(posedge clk); #2;
        ack = 1'b0; nop();
        @(negedge clk);
        chk("ld result_w", result_w, 32'hDEADBEEF);
        chk("ld rd_w", {27'd0, rd_w}, 32'd7);
        chk("ld req drop", {31'd0, bus_req}, 32'd0);

        // store 0x204
        @(posedge clk); #2;
        set_op(5'd3, 32'h204, 32'hA5A5A5A5, 1'b0, 2'b00, 1'b1);
        @(negedge clk); chk("st stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #2;
        ack = 1'b1;
        @(negedge clk);
        chk("st req", {31'd0, bus_req}, 32'd1);
        chk("st we", {31'd0, bus_we}, 32'd1);
        chk("st addr", bus_addr, 32'h204);
        chk("st wdata", bus_wdata, 32'hA5A5A5A5);
        @(posedge clk); #2;
        ack = 1'b0; nop();
        @(negedge clk);
        chk("st req drop", {31'd0, bus_req}, 32'd0);
        chk("st reg_wr_w", {31'd0, reg_wr_w}, 32'd0);

        // misaligned load 0x102
        @(posedge clk); #2;
        set_op(5'd9, 32'h102, 32'd0, 1'b1, 2'b01, 1'b0);
        @(negedge clk);
        chk("mis flag", {31'd0, mis}, 32'd1);
        chk("mis stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        nop();
        @(negedge clk);
        chk("mis req", {31'd0, bus_req}, 32'd0);
        chk("mis reg_wr_w", {31'd0, reg_wr_w}, 32'd0);

        // timeout: never ack
        @(posedge clk); #2;
        set_op(5'd4, 32'h40, 32'd0, 1'b1, 2'b01, 1'b0);
        rq = 0; er = 0; st = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rq += int'(bus_req); er += int'(bus_err); st += int'(stall);
            if (bus_err) chk("to reg_wr_w", {31'd0, reg_wr_w}, 32'd0);
            stall_now = stall;
            @(posedge clk); #2;
            if (!stall_now) nop();
        end
        chk("to req cycles", rq, 32'd4);
        chk("to err pulses", er, 32'd1);
        chk("to stall cycles", st, 32'd4);

        // reset during WAIT, later ack ignored
        set_op(5'd6, 32'h80, 32'h55, 1'b1, 2'b01, 1'b0);
        @(posedge clk); #2;
        @(negedge clk); chk("rw req", {31'd0, bus_req}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; ack = 1'b1; rdata = 32'h12345678;
        @(negedge clk);
        chk("rw req0", {31'd0, bus_req}, 32'd0);
        chk("rw addr0", bus_addr, 32'd0);
        chk("rw result0", result_w, 32'd0);
        @(posedge clk); #2;
        ack = 1'b0;
        @(negedge clk);
        chk("rw no wb", {31'd0, reg_wr_w}, 32'd0);
        chk("rw no result", result_w, 32'd0);

        // randomized traffic; EX/MEM only advances when not stalled
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            adv = rst | (en & ~e_stall);
            if (adv) rand_op();
            ack   = ($urandom_range(0, 3) == 0);
            rdata = $urandom;
            en    = ($urandom_range(0, 7) != 0);
            rst   = ($urandom_range(0, 63) == 0);
            if (rst) en = 1'b1;
        end
        @(posedge clk); #2;
        rst = 1'b0; en = 1'b1;
        @(negedge clk);
        @(posedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
